filter: RTL and testbench



---
 rtl/filter_pkg.sv | 23 ++
 rtl/filter_if.sv | 15 +
 rtl/filter_round_sat.sv | 32 +++
 rtl/filter.sv | 58 +++++
 tb/tb_filter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared constants for the 16-tap symmetric low-pass FIR.
// Holds the widths, the Q1.13 coefficient table and the rounding constant.
package filter_pkg;

  localparam int unsigned TAPS   = 16;
  localparam int unsigned DATA_W = 14;
  localparam int unsigned COEF_W = 14;
  localparam int unsigned FRAC_W = 13;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  // Symmetric taps; the table sums to 8192 so the DC gain is exactly 1.0.
  localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
    -14'sd40,  -14'sd90,  -14'sd100, 14'sd60,
     14'sd400,  14'sd900,  14'sd1350, 14'sd1616,
     14'sd1616, 14'sd1350, 14'sd900,  14'sd400,
     14'sd60,  -14'sd100, -14'sd90,  -14'sd40
  };

  // Half an output LSB, added before the shift for round half-up.
  localparam logic signed [ACC_W-1:0] ROUND_C = 32'sd4096;

endpackage

// File: rtl/filter_if.sv
// Sample-stream bundle for the FIR: enable, input sample and filtered output.
//   clk_enable : advance delay line and output register when 1
//   filter_in  : Q1.13 signed input sample
//   filter_out : Q1.13 signed registered output sample
interface filter_if;
  import filter_pkg::*;

  logic                     clk_enable;
  logic signed [DATA_W-1:0] filter_in;
  logic signed [DATA_W-1:0] filter_out;

  modport slave  (input  clk_enable, input  filter_in, output filter_out);
  modport master (output clk_enable, output filter_in, input  filter_out);

endinterface

// File: rtl/filter_round_sat.sv
// Converts the full-precision accumulator to a Q1.13 output sample.
//   i_acc    : 32-bit signed sum with 26 fractional bits
//   o_sample : round half-up, then saturated to -8192..8191
module filter_round_sat
  import filter_pkg::*;
(
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_sample
);

  localparam int MAX_I = (1 << (DATA_W - 1)) - 1;
  localparam int MIN_I = -(1 << (DATA_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(MIN_I);

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shift;

  // The accumulator has ample headroom, so adding the rounding term cannot wrap.
  assign w_sum   = i_acc + ROUND_C;
  assign w_shift = w_sum >>> FRAC_W;

  always_comb begin
    o_sample = w_shift[DATA_W-1:0];
    if (w_shift > MAX_V) begin
      o_sample = MAX_V[DATA_W-1:0];
    end else if (w_shift < MIN_V) begin
      o_sample = MIN_V[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/filter.sv
// Direct-form 16-tap symmetric FIR, single combinational MAC per sample.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears delay line and output
//   bus   : filter_if slave (clk_enable, filter_in, filter_out)
module filter
  import filter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  filter_if.slave  bus
);

  logic signed [DATA_W-1:0] r_taps [TAPS];
  logic signed [DATA_W-1:0] r_out;
  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_sample;

  // Delay line: tap0 takes the new sample, the rest shift by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        r_taps[i] <= '0;
      end
    end else if (bus.clk_enable) begin
      r_taps[0] <= bus.filter_in;
      for (int unsigned i = 1; i < TAPS; i++) begin
        r_taps[i] <= r_taps[i-1];
      end
    end
  end

  // Full-precision multiply-accumulate over the current taps.
  always_comb begin
    w_acc = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      w_prod[i] = PROD_W'(COEFS[i]) * PROD_W'(r_taps[i]);
      w_acc     = w_acc + ACC_W'(w_prod[i]);
    end
  end

  filter_round_sat u_round_sat (
    .i_acc    (w_acc),
    .o_sample (w_sample)
  );

  // Output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (bus.clk_enable) begin
      r_out <= w_sample;
    end
  end

  assign bus.filter_out = r_out;

endmodule

// File: tb/tb_filter.sv
// Self-checking bench for the FIR: directed plan steps plus random stream
// against a convolution model of the filter.
module tb_filter;

  logic clk;
  logic reset;
  filter_if bus ();

  filter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int coef [16] = '{-40, -90, -100, 60, 400, 900, 1350, 1616,
                    1616, 1350, 900, 400, 60, -100, -90, -40};
  int hist [16];   // hist[0] is the most recently captured sample
  int ref_out = 0;

  int imp_exp [17] = '{-20, -45, -50, 30, 200, 450, 675, 808,
                       808, 675, 450, 200, 30, -50, -45, -20, 0};
  int step_exp [4] = '{-36, -117, -207, -153};

  // Output the filter should register: convolution, round half-up, clip.
  function automatic int conv_out();
    int acc, r, q;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += coef[i] * hist[i];
    r = acc + 4096;
    q = r / 8192;
    if (r < 0 && q * 8192 != r) q = q - 1;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) hist[i] = 0;
    ref_out = 0;
  endfunction

  // One clock with given input/enable; model advances only on enabled edges.
  task automatic drive(input int smp, input bit en);
    bus.filter_in  = 14'(smp);
    bus.clk_enable = en;
    @(posedge clk);
    if (en) begin
      ref_out = conv_out();
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = smp;
    end
    #1;
    check("model", int'(bus.filter_out), ref_out);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", int'(bus.filter_out), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic impulse_test(input string tag);
    drive(4096, 1'b1);
    check({tag, "_cap"}, int'(bus.filter_out), 0);
    for (int j = 0; j < 17; j++) begin
      drive(0, 1'b1);
      check(tag, int'(bus.filter_out), imp_exp[j]);
    end
  endtask

  int pat [16];
  int held;

  initial begin
    reset = 1'b1;
    bus.filter_in  = 14'sd1234;
    bus.clk_enable = 1'b1;
    model_clear();

    // Reset held for 4 cycles with a non-zero input.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("reset", int'(bus.filter_out), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1234, 1'b1);
    check("first_edge", int'(bus.filter_out), 0);

    // Impulse response.
    do_reset();
    impulse_test("impulse");

    // Step response and settling.
    do_reset();
    drive(7373, 1'b1);
    for (int j = 0; j < 4; j++) begin
      drive(7373, 1'b1);
      check("step_ramp", int'(bus.filter_out), step_exp[j]);
    end
    for (int j = 4; j < 16; j++) drive(7373, 1'b1);
    check("step_settle", int'(bus.filter_out), 7373);
    for (int j = 0; j < 100; j++) begin
      drive(7373, 1'b1);
      check("step_hold", int'(bus.filter_out), 7373);
    end

    // Enable gating during a step; disabled input differs to prove it is ignored.
    do_reset();
    for (int j = 0; j < 7; j++) drive(7373, 1'b1);
    held = ref_out;
    for (int j = 0; j < 5; j++) begin
      drive(-5000, 1'b0);
      check("gate_freeze", int'(bus.filter_out), held);
    end
    for (int j = 7; j < 17; j++) drive(7373, 1'b1);
    check("gate_resume", int'(bus.filter_out), 7373);

    // Positive and negative saturation with sign-matched patterns.
    for (int i = 0; i < 16; i++) pat[i] = (coef[i] > 0) ? 8191 : -8192;
    do_reset();
    for (int i = 0; i < 16; i++) drive(pat[i], 1'b1);
    drive(0, 1'b1);
    check("sat_pos", int'(bus.filter_out), 8191);
    do_reset();
    for (int i = 0; i < 16; i++) drive((pat[i] > 0) ? -8192 : 8191, 1'b1);
    drive(0, 1'b1);
    check("sat_neg", int'(bus.filter_out), -8192);

    // Full-scale negative constant.
    do_reset();
    for (int i = 0; i < 17; i++) drive(-8192, 1'b1);
    check("full_scale", int'(bus.filter_out), -8192);

    // Random stream with random enable against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(int'($urandom_range(16383)) - 8192, ($urandom_range(9) < 8));
    end

    // Asynchronous reset between edges while the output is live.
    for (int i = 0; i < 8; i++) drive(6000, 1'b1);
    check("pre_reset_live", int'(bus.filter_out != 0), 1);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_reset", int'(bus.filter_out), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("post_release", int'(bus.filter_out), 0);
    impulse_test("impulse_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
